// File: rtl/calc_host_ctrl.sv
// calc_host_ctrl -- initiator for the calculator device command protocol.
//
// Takes one command (plus up to two operands) from a valid/ready request
// port, waits for the device to go idle, then serializes the command byte
// and the operands the command needs onto dev_cs/dev_din.  Commands with
// b_tx set wait for dev_drdy and return dev_dout on the response port.
// Every transaction ends with a single-cycle rsp_valid pulse.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (accept when both high)
//   req_cmd, req_op1, req_op2   command byte and operands (DW bits each)
//   rsp_valid                   one-cycle pulse: transaction finished
//   rsp_data                    device result (0 for commands without b_tx)
//   rsp_err                     timeout flag, qualified by rsp_valid
//   dev_cs, dev_din             device chip select and data input
//   dev_busy, dev_dout, dev_drdy device busy, result, result-ready
//   txn_cnt                     completed-transaction counter (wraps)
//
// Build option:
//   CALC_HOST_TIMEOUT_EN -- when defined, the read phase gives up after
//   TO_CYC cycles without dev_drdy, finishing with rsp_err=1, rsp_data=0.
//   When undefined the read phase waits indefinitely and rsp_err stays 0.

package cmd_bits;
  localparam int b_addop  = 0;
  localparam int b_subop  = 1;
  localparam int b_addres = 2;
  localparam int b_subres = 3;
  localparam int b_op_2   = 4;
  localparam int b_tx     = 5;
endpackage

module calc_host_ctrl
  import cmd_bits::*;
#(
  parameter int DW     = 8,
  parameter int TO_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] req_cmd,
  input  logic [DW-1:0] req_op1,
  input  logic [DW-1:0] req_op2,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          dev_cs,
  output logic [DW-1:0] dev_din,
  input  logic          dev_busy,
  input  logic [DW-1:0] dev_dout,
  input  logic          dev_drdy,
  output logic [15:0]   txn_cnt
);

`ifdef CALC_HOST_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // Timeout counter is at least 8 bits, wider if TO_CYC needs it.
  localparam int TO_W = (TO_CYC > 255) ? $clog2(TO_CYC + 1) : 8;
  // Counter value seen in the last permitted RD cycle (first RD cycle sees 0).
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TO_CYC > 0) ? (TO_CYC - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_CMD,
    S_OP1,
    S_OP2,
    S_RD,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [DW-1:0]   cmd_reg, op1_reg, op2_reg;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;

  logic            req_ready_reg, req_ready_next;
  logic            dev_cs_reg, dev_cs_next;
  logic [DW-1:0]   dev_din_reg, dev_din_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic [DW-1:0]   rsp_data_reg, rsp_data_next;
  logic            rsp_err_reg, rsp_err_next;
  logic [15:0]     txn_cnt_reg, txn_cnt_next;

  logic accept;
  logic need_op1, need_op2, need_rd;
  logic timeout_hit;
  logic enter_cmd;

  // Handshake uses the registered ready so a request is only taken in a
  // cycle where req_ready is actually visible to the requester.
  assign accept   = (state_reg == S_IDLE) && req_valid && req_ready_reg;

  // Any arithmetic bit means one op1 byte, regardless of how many are set.
  assign need_op1 = cmd_reg[b_addop] | cmd_reg[b_subop] |
                    cmd_reg[b_addres] | cmd_reg[b_subres];
  assign need_op2 = cmd_reg[b_op_2];
  assign need_rd  = cmd_reg[b_tx];

  assign timeout_hit = TIMEOUT_EN && (to_cnt_reg == TO_LAST);
  assign enter_cmd   = (state_reg == S_WAIT_BUSY) && (state_next == S_CMD);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cmd_reg       <= '0;
      op1_reg       <= '0;
      op2_reg       <= '0;
      to_cnt_reg    <= '0;
      req_ready_reg <= 1'b0;
      dev_cs_reg    <= 1'b0;
      dev_din_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      txn_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      to_cnt_reg    <= to_cnt_next;
      req_ready_reg <= req_ready_next;
      dev_cs_reg    <= dev_cs_next;
      dev_din_reg   <= dev_din_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
      txn_cnt_reg   <= txn_cnt_next;
      if (accept) begin
        cmd_reg <= req_cmd;
        op1_reg <= req_op1;
        op2_reg <= req_op2;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (accept) state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!dev_busy) state_next = S_CMD;
      end
      S_CMD: begin
        if (need_op1)      state_next = S_OP1;
        else if (need_op2) state_next = S_OP2;
        else if (need_rd)  state_next = S_RD;
        else               state_next = S_DONE;
      end
      S_OP1: begin
        if (need_op2)      state_next = S_OP2;
        else if (need_rd)  state_next = S_RD;
        else               state_next = S_DONE;
      end
      S_OP2: begin
        if (need_rd) state_next = S_RD;
        else         state_next = S_DONE;
      end
      S_RD: begin
        if (dev_drdy || timeout_hit) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: values are computed for the state being entered so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    req_ready_next = (state_next == S_IDLE);
    dev_cs_next    = (state_next == S_CMD);
    rsp_valid_next = (state_next == S_DONE);

    dev_din_next = '0;
    unique case (state_next)
      S_CMD:   dev_din_next = cmd_reg;
      S_OP1:   dev_din_next = op1_reg;
      S_OP2:   dev_din_next = op2_reg;
      default: dev_din_next = '0;
    endcase

    // Free-running in RD, zero everywhere else, so it starts at 0 on RD entry.
    to_cnt_next = (state_reg == S_RD) ? (to_cnt_reg + TO_W'(1)) : '0;

    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    if (enter_cmd) begin
      rsp_err_next = 1'b0;
      if (!need_rd) rsp_data_next = '0;
    end
    if (state_reg == S_RD) begin
      if (dev_drdy) begin
        rsp_data_next = dev_dout;
        rsp_err_next  = 1'b0;
      end else if (timeout_hit) begin
        rsp_data_next = '0;
        rsp_err_next  = 1'b1;
      end
    end

    txn_cnt_next = txn_cnt_reg;
    if ((state_next == S_DONE) && (state_reg != S_DONE))
      txn_cnt_next = txn_cnt_reg + 16'd1;
  end

  assign req_ready = req_ready_reg;
  assign dev_cs    = dev_cs_reg;
  assign dev_din   = dev_din_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign txn_cnt   = txn_cnt_reg;

endmodule

// File: tb/tb_calc_host_ctrl.sv
// Testbench for calc_host_ctrl: directed protocol scenarios plus randomized
// transactions, checked against a transaction-level model that derives the
// expected byte stream, response cycle and response data from the command.
module tb_calc_host_ctrl;
  import cmd_bits::*;

  localparam int DW   = 8;
  localparam int TO   = 10;
  localparam int MAXC = 250;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_cmd, req_op1, req_op2;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          dev_cs;
  logic [DW-1:0] dev_din;
  logic          dev_busy;
  logic [DW-1:0] dev_dout;
  logic          dev_drdy;
  logic [15:0]   txn_cnt;

  always #5 clk = ~clk;

  calc_host_ctrl #(.DW(DW), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dev_cs(dev_cs), .dev_din(dev_din),
    .dev_busy(dev_busy), .dev_dout(dev_dout), .dev_drdy(dev_drdy),
    .txn_cnt(txn_cnt)
  );

  int tests = 0;
  int fails = 0;
  int model_txn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction. Called at a negedge; returns at the negedge of the
  // rsp_valid cycle. Cycle i = i-th negedge after the accepting edge.
  // drdy_dly < 0 means the device never raises dev_drdy.
  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] op1, input logic [7:0] op2,
                         input int busy_cyc, input int drdy_dly, input logic [7:0] dout,
                         input bit hold_next, input logic [7:0] ncmd, input logic [7:0] nop1,
                         output int waits);
    logic [7:0] exp_bytes[$];
    logic [7:0] din_obs[0:MAXC];
    logic       cs_obs[0:MAXC];
    bit   tx, never;
    int   exp_cs, r_start, exp_rsp, t_rdy;
    int   cs_i, rsp_i, cs_cnt, cs_busy, ready_hi, stray;
    logic [7:0] got_data;
    logic       got_err;
    logic [7:0] exp_data;
    logic       exp_err;

    tx    = cmd[b_tx];
    never = (drdy_dly < 0);
    exp_bytes.push_back(cmd);
    if (cmd[b_addop] || cmd[b_subop] || cmd[b_addres] || cmd[b_subres]) exp_bytes.push_back(op1);
    if (cmd[b_op_2]) exp_bytes.push_back(op2);
    exp_cs  = ((busy_cyc > 1) ? busy_cyc : 1) + 1;
    r_start = exp_cs + exp_bytes.size();
    if (!tx) exp_rsp = r_start;
    else if (never) exp_rsp = r_start + TO;
    else begin
      t_rdy   = exp_cs + drdy_dly;
      exp_rsp = ((r_start > t_rdy) ? r_start : t_rdy) + 1;
    end
    exp_data = (tx && !never) ? dout : 8'h00;
    exp_err  = tx && never;

    req_cmd   = cmd;
    req_op1   = op1;
    req_op2   = op2;
    req_valid = 1'b1;
    dev_busy  = (busy_cyc > 0);
    dev_drdy  = 1'b0;
    dev_dout  = ~dout;

    waits = 0;
    while (req_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    check("txn_cnt_at_accept", txn_cnt, model_txn);

    cs_i = -1; rsp_i = -1; cs_cnt = 0; cs_busy = 0; ready_hi = 0;
    got_data = '0; got_err = 1'b0;
    for (int i = 1; i <= MAXC; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (hold_next) begin
          req_cmd = ncmd;
          req_op1 = nop1;
          req_op2 = 8'h00;
        end else begin
          req_valid = 1'b0;
        end
      end
      din_obs[i] = dev_din;
      cs_obs[i]  = dev_cs;
      if (dev_cs) begin
        cs_cnt++;
        if (dev_busy) cs_busy++;
        if (cs_i < 0) cs_i = i;
      end
      if (req_ready) ready_hi++;
      if (rsp_valid) begin
        rsp_i    = i;
        got_data = rsp_data;
        got_err  = rsp_err;
        dev_drdy = 1'b0;
        dev_busy = 1'b0;
        break;
      end
      dev_busy = (i < busy_cyc);
      dev_drdy = tx && !never && (cs_i > 0) && (i >= cs_i + drdy_dly);
      dev_dout = dev_drdy ? dout : ~dout;
    end

    if (rsp_i < 0) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end

    stray = 0;
    for (int j = 1; j <= rsp_i; j++)
      if ((j < exp_cs || j >= exp_cs + exp_bytes.size()) && din_obs[j] !== 8'h00) stray++;

    check("cs_cycle", cs_i, exp_cs);
    check("cs_count", cs_cnt, 1);
    check("cs_while_busy", cs_busy, 0);
    for (int k = 0; k < exp_bytes.size(); k++) begin
      if (exp_cs + k <= rsp_i) begin
        check("din_byte", din_obs[exp_cs + k], exp_bytes[k]);
        if (k > 0) check("cs_on_operand", cs_obs[exp_cs + k], 1'b0);
      end else begin
        check("din_byte_missing", 32'd0, 32'd1);
      end
    end
    check("din_idle_zero", stray, 0);
    check("rsp_cycle", rsp_i, exp_rsp);
    check("rsp_data", got_data, exp_data);
    check("rsp_err", got_err, exp_err);
    check("ready_low_in_txn", ready_hi, 0);
    model_txn = (model_txn + 1) & 16'hFFFF;

    $display("[TB] txn cmd=%02h op1=%02h op2=%02h busy=%0d dly=%0d -> cs@%0d rsp@%0d data=%02h err=%0d",
             cmd, op1, op2, busy_cyc, drdy_dly, cs_i, rsp_i, got_data, got_err);
  endtask

  // Negedge after a response: pulse must be gone, counter must match model.
  task automatic post_check();
    @(negedge clk);
    check("rsp_pulse_width", rsp_valid, 1'b0);
    check("txn_cnt", txn_cnt, model_txn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cnt;
    logic [7:0] c, a, b, d;
    int bc, dl;

    rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
    dev_busy = 1'b0; dev_dout = '0; dev_drdy = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_dev_cs", dev_cs, 1'b0);
    check("rst_dev_din", dev_din, 8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_txn_cnt", txn_cnt, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);

    // Two-operand add, no read
    run_txn(8'((1 << b_op_2) | (1 << b_addop)), 8'h12, 8'h34, 0, 1, 8'h00, 1'b0, 8'h00, 8'h00, w);
    post_check();
    // Read-only command, drdy 4 cycles after CMD
    run_txn(8'(1 << b_tx), 8'h77, 8'h88, 0, 4, 8'h46, 1'b0, 8'h00, 8'h00, w);
    post_check();
    // cmd = 0: CMD cycle then DONE
    run_txn(8'h00, 8'h11, 8'h22, 0, 1, 8'h00, 1'b0, 8'h00, 8'h00, w);
    post_check();
    // Busy held for 6 cycles at acceptance
    run_txn(8'((1 << b_subop) | (1 << b_tx)), 8'h9C, 8'h00, 6, 2, 8'hE1, 1'b0, 8'h00, 8'h00, w);
    post_check();
    // Several arithmetic bits still give a single op1 byte
    run_txn(8'h0F, 8'h3C, 8'hC3, 1, 1, 8'h00, 1'b0, 8'h00, 8'h00, w);
    post_check();

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      c  = 8'($urandom_range(0, 255));
      a  = 8'($urandom);
      b  = 8'($urandom);
      d  = 8'($urandom);
      bc = $urandom_range(0, 3);
      dl = $urandom_range(1, 6);
      run_txn(c, a, b, bc, dl, d, 1'b0, 8'h00, 8'h00, w);
      post_check();
    end

    // Reset held two cycles in the middle of OP1
    req_cmd = 8'((1 << b_addop) | (1 << b_op_2)); req_op1 = 8'hA5; req_op2 = 8'h5A;
    req_valid = 1'b1;
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    @(negedge clk); req_valid = 1'b0;      // WAIT_BUSY
    @(negedge clk);                        // CMD
    check("pre_rst_cs", dev_cs, 1'b1);
    @(negedge clk);                        // OP1
    check("pre_rst_op1", dev_din, 8'hA5);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_cs", dev_cs, 1'b0);
      check("midrst_din", dev_din, 8'h00);
      check("midrst_rsp_valid", rsp_valid, 1'b0);
      check("midrst_txn_cnt", txn_cnt, 16'h0000);
      check("midrst_ready", req_ready, 1'b0);
    end
    rst = 1'b0;
    model_txn = 0;
    @(negedge clk);
    check("ready_after_midrst", req_ready, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid || dev_cs) cnt++;
      @(negedge clk);
    end
    check("abandoned_no_activity", cnt, 0);
    $display("[TB] txn reset mid-OP1 -> abandoned, txn_cnt=%0d", txn_cnt);

    // Back-to-back requests with req_valid held high
    run_txn(8'(1 << b_addres), 8'h05, 8'h00, 0, 1, 8'h00, 1'b1, 8'(1 << b_subres), 8'h03, w);
    check("b2b_rsp_then_ready", req_ready, 1'b0);
    run_txn(8'(1 << b_subres), 8'h03, 8'h00, 0, 1, 8'h00, 1'b0, 8'h00, 8'h00, w);
    check("b2b_second_wait", w, 1);
    post_check();
    check("b2b_txn_cnt_two", txn_cnt, 16'd2);

    // Read that never receives dev_drdy
`ifdef CALC_HOST_TIMEOUT_EN
    run_txn(8'(1 << b_tx), 8'h00, 8'h00, 0, -1, 8'h5D, 1'b0, 8'h00, 8'h00, w);
    post_check();
`else
    req_cmd = 8'(1 << b_tx); req_op1 = 8'h00; req_op2 = 8'h00;
    req_valid = 1'b1;
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    @(negedge clk); req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("stuck_no_rsp", cnt, 0);
    check("stuck_ready_low", req_ready, 1'b0);
    check("stuck_din_zero", dev_din, 8'h00);
    check("stuck_txn_cnt", txn_cnt, model_txn);
    $display("[TB] txn cmd=%02h no drdy -> still waiting after 300 cycles", 8'(1 << b_tx));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_txn = 0;
    @(negedge clk);
    check("ready_after_stuck_rst", req_ready, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_host_ctrl.md
Name: calc_host_ctrl

Overview:
- Synthesizable initiator for the calculator device command protocol.
- Accepts a command plus operands from a local valid/ready request port and serializes them onto the device bus (cs, din).
- For read commands (b_tx), waits for drdy and returns the device result on a response port.
- Sits between the system-side controller and dev_fsm; command bit positions come from package cmd_bits.

Parameters:
- DW, 8, data/command width; must equal the device DW.
- TO_CYC, 255, drdy wait limit in clocks; only used when the optional feature is compiled in.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_cmd  in  DW  command byte, bits per cmd_bits.
- req_op1  in  DW  first operand.
- req_op2  in  DW  second operand.
- rsp_valid  out  1  one-cycle pulse: transaction finished.
- rsp_data  out  DW  device result; valid with rsp_valid when the command had b_tx, else 0.
- rsp_err  out  1  timeout flag; valid with rsp_valid.
- dev_cs  out  1  device chip select.
- dev_din  out  DW  device data input.
- dev_busy  in  1  device busy.
- dev_dout  in  DW  device result.
- dev_drdy  in  1  device result ready.
- txn_cnt  out  16  completed-transaction counter; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - dev_cs=0, dev_din=0, req_ready=0 in the reset cycle, rsp_valid=0, rsp_data=0, rsp_err=0, txn_cnt=0.
  - Reset mid-transaction abandons the transaction immediately; no rsp_valid is produced.
- All outputs are registered. dev_din=0 in every state that is not driving it.
- States:
  - IDLE: req_ready=1. On req_valid, latch cmd/op1/op2 into internal registers, then go to WAIT_BUSY.
  - WAIT_BUSY: stay while dev_busy=1. When dev_busy=0, go to CMD.
  - CMD: exactly one cycle with dev_cs=1, dev_din=cmd.
    - Next state is OP1 if any of b_subres/b_addres/b_subop/b_addop is set.
    - Else OP2 if b_op_2 is set.
    - Else RD if b_tx is set.
    - Else DONE.
  - OP1: one cycle with dev_cs=0, dev_din=op1. Next state is OP2 if b_op_2, else RD if b_tx, else DONE.
  - OP2: one cycle with dev_din=op2. Next state is RD if b_tx, else DONE.
  - RD: dev_din=0. Wait for dev_drdy=1; on that edge capture dev_dout into rsp_data and go to DONE. If dev_drdy is already 1 on the first RD cycle, it is captured on that cycle.
  - DONE: one cycle with rsp_valid=1. txn_cnt increments (wrapping). Return to IDLE.
- Latency, no busy stall:
  - 1 cycle to WAIT_BUSY, 1 cycle CMD, plus 1 per operand, plus drdy wait, plus 1 cycle DONE.
  - Example: add-two-operands with no b_tx: req accepted at edge N, dev_cs=1 during cycle N+2, rsp_valid during cycle N+5.
- A command with multiple arithmetic bits still sends a single op1 byte.
- A command with cmd=0 still issues the CMD cycle, then goes to DONE.
- req_ready=0 outside IDLE. Requests offered then are not lost; they wait (valid/ready semantics).
- rsp_data is cleared to 0 on entry to CMD for commands without b_tx.

Optional Feature:
- Macro: CALC_HOST_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter runs in RD.
  - If dev_drdy has not arrived after TO_CYC cycles, go to DONE with rsp_err=1 and rsp_data=0.
  - The counter clears on entering RD.
- Not defined: RD waits indefinitely, and rsp_err is tied to 0.

Test Plan:
- Reset held 2 cycles mid-OP1 -> dev_cs=0, dev_din=0, rsp_valid never pulses, txn_cnt=0, req_ready=1 one cycle after reset release.
- req_cmd=(1<<b_op_2)|(1<<b_addop), op1=0x12, op2=0x34, dev_busy=0 -> dev_din sequence cmd,0x12,0x34 on consecutive cycles; dev_cs high only on the cmd cycle; rsp_valid 3 cycles after CMD; rsp_data=0.
- req_cmd=(1<<b_tx), device model asserts dev_drdy 4 cycles after CMD with dev_dout=0x46 -> rsp_data=0x46 with rsp_valid; no operand cycles.
- dev_busy held high 6 cycles when the request is accepted -> CMD cycle starts on the first cycle after dev_busy falls; dev_cs is never asserted while busy.
- Back-to-back requests with req_valid held high, commands (1<<b_addres) op1=0x05 then (1<<b_subres) op1=0x03 -> second request accepted only after rsp_valid of the first; txn_cnt=2.
- With CALC_HOST_TIMEOUT_EN and TO_CYC=10, b_tx command with dev_drdy never asserted -> rsp_valid with rsp_err=1, rsp_data=0 after 10 RD cycles.
- Without CALC_HOST_TIMEOUT_EN, the same stimulus -> stays in RD, req_ready=0.
